// File: rtl/tetris_pkg.sv
// Shared constants and types for the Tetris playfield controller.
package tetris_pkg;

  localparam int unsigned ROWS      = 12;
  localparam int unsigned COLS      = 10;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned NCELLS    = 4;
  localparam int unsigned CELL_W    = 8;
  localparam int unsigned ROW_W     = 4;
  localparam int unsigned COL_W     = 4;
  localparam int unsigned PTR_W     = 4;
  localparam int unsigned MAX_CLEAR = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SCAN,
    ST_SHIFT,
    ST_FIN
  } state_t;

  typedef logic [COLS-1:0] row_t;

  // True when a {row,col} cell lies on the playfield.
  function automatic logic cell_on_board(input logic [ROW_W-1:0] row,
                                         input logic [COL_W-1:0] col);
    return (32'(row) < ROWS) && (32'(col) < COLS);
  endfunction

endpackage

// File: rtl/tetris_row_shift.sv
// Combinational row drop: removes the row at the pointer by moving every
// row above it down by one and emptying the top row.
module tetris_row_shift
  import tetris_pkg::*;
(
  input  row_t             board_i [ROWS],
  input  logic [PTR_W-1:0] ptr_i,
  output row_t             board_o [ROWS]
);

  // Rows 1..ptr take the row above them; rows below ptr are untouched.
  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      board_o[r] = board_i[r];
      if (r == 0) begin
        board_o[r] = '0;
      end else if (r <= 32'(ptr_i)) begin
        board_o[r] = board_i[r-1];
      end
    end
  end

endmodule

// File: rtl/tetris_board_ctrl.sv
// Playfield owner: merges locked pieces into the board, removes full rows,
// and reports lines cleared and game-over.
module tetris_board_ctrl
  import tetris_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear_all,
  input  logic             lock_valid,
  output logic             lock_ready,
  input  logic [31:0]      lock_cells,
  output logic [COLS-1:0]  arr0,
  output logic [COLS-1:0]  arr1,
  output logic [COLS-1:0]  arr2,
  output logic [COLS-1:0]  arr3,
  output logic [COLS-1:0]  arr4,
  output logic [COLS-1:0]  arr5,
  output logic [COLS-1:0]  arr6,
  output logic [COLS-1:0]  arr7,
  output logic [COLS-1:0]  arr8,
  output logic [COLS-1:0]  arr9,
  output logic [COLS-1:0]  arr10,
  output logic [COLS-1:0]  arr11,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] lines_cleared,
  output logic             game_over
);

  state_t           state_q;
  row_t             board_q [ROWS];
  logic [31:0]      cells_q;
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] lines_q;
  logic             done_q;
  logic             busy_q;
  logic             go_q;

  row_t             wr_board_d    [ROWS];
  row_t             shift_board_d [ROWS];

  tetris_row_shift u_row_shift (
    .board_i (board_q),
    .ptr_i   (ptr_q),
    .board_o (shift_board_d)
  );

  // Board with the captured piece cells OR-ed in; off-board cells are dropped.
  always_comb begin
    wr_board_d = board_q;
    for (int unsigned k = 0; k < NCELLS; k++) begin
      if (cell_on_board(cells_q[k*CELL_W+COL_W +: ROW_W], cells_q[k*CELL_W +: COL_W])) begin
        wr_board_d[cells_q[k*CELL_W+COL_W +: ROW_W]][cells_q[k*CELL_W +: COL_W]] = 1'b1;
      end
    end
  end

  // Sequencer: accept, write, scan bottom-up, shift out full rows, finish.
  // done/lines_cleared/game_over are loaded on the SCAN->FIN edge so they are
  // visible as registered outputs during the FIN cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      board_q <= '{default: '0};
      cells_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      go_q    <= 1'b0;
    end else if (clear_all) begin
      state_q <= ST_IDLE;
      board_q <= '{default: '0};
      ptr_q   <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (lock_valid) begin
            cells_q <= lock_cells;
            state_q <= ST_WRITE;
            busy_q  <= 1'b1;
          end
        end
        ST_WRITE: begin
          board_q <= wr_board_d;
          ptr_q   <= PTR_W'(ROWS - 1);
          cnt_q   <= '0;
          state_q <= ST_SCAN;
        end
        ST_SCAN: begin
          if (&board_q[ptr_q]) begin
            state_q <= ST_SHIFT;
          end else if (ptr_q == '0) begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
            lines_q <= cnt_q;
            go_q    <= go_q | (|board_q[0]);
          end else begin
            ptr_q <= ptr_q - PTR_W'(1);
          end
        end
        ST_SHIFT: begin
          board_q <= shift_board_d;
          if (cnt_q != CNT_W'(MAX_CLEAR)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          state_q <= ST_SCAN;
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign lock_ready    = (state_q == ST_IDLE);
  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_cleared = lines_q;
  assign game_over     = go_q;

  assign arr0  = board_q[0];
  assign arr1  = board_q[1];
  assign arr2  = board_q[2];
  assign arr3  = board_q[3];
  assign arr4  = board_q[4];
  assign arr5  = board_q[5];
  assign arr6  = board_q[6];
  assign arr7  = board_q[7];
  assign arr8  = board_q[8];
  assign arr9  = board_q[9];
  assign arr10 = board_q[10];
  assign arr11 = board_q[11];

endmodule

// File: tb/tb_tetris_board_ctrl.sv
// Self-checking bench for tetris_board_ctrl: a board-level model (place cells,
// then compact away full rows) predicts results; a per-cycle compare process
// checks all outputs, and directed tests pin the model with literal values.
module tb_tetris_board_ctrl;
  import tetris_pkg::*;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             clear_all;
  logic             lock_valid;
  logic             lock_ready;
  logic [31:0]      lock_cells;
  logic [COLS-1:0]  arr0, arr1, arr2, arr3, arr4, arr5, arr6, arr7, arr8, arr9, arr10, arr11;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] lines_cleared;
  logic             game_over;

  logic [COLS-1:0]  dut_rows [ROWS];

  tetris_board_ctrl dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .clear_all     (clear_all),
    .lock_valid    (lock_valid),
    .lock_ready    (lock_ready),
    .lock_cells    (lock_cells),
    .arr0          (arr0),
    .arr1          (arr1),
    .arr2          (arr2),
    .arr3          (arr3),
    .arr4          (arr4),
    .arr5          (arr5),
    .arr6          (arr6),
    .arr7          (arr7),
    .arr8          (arr8),
    .arr9          (arr9),
    .arr10         (arr10),
    .arr11         (arr11),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .game_over     (game_over)
  );

  assign dut_rows[0]  = arr0;
  assign dut_rows[1]  = arr1;
  assign dut_rows[2]  = arr2;
  assign dut_rows[3]  = arr3;
  assign dut_rows[4]  = arr4;
  assign dut_rows[5]  = arr5;
  assign dut_rows[6]  = arr6;
  assign dut_rows[7]  = arr7;
  assign dut_rows[8]  = arr8;
  assign dut_rows[9]  = arr9;
  assign dut_rows[10] = arr10;
  assign dut_rows[11] = arr11;

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Model state: m_* = board after every accepted lock completes,
  // p_* = result of the lock in flight, e_* = what the outputs show now.
  logic [COLS-1:0] m_board [ROWS];
  logic [COLS-1:0] p_board [ROWS];
  logic [COLS-1:0] e_board [ROWS];
  int unsigned     m_lines, p_lines, e_lines;
  bit              m_go, p_go, e_go;
  bit              pending = 1'b0;
  int unsigned     acc_cyc;
  int unsigned     done_cyc;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cells4(input int r0, input int c0, input int r1, input int c1,
                                         input int r2, input int c2, input int r3, input int c3);
    return {4'(r3), 4'(c3), 4'(r2), 4'(c2), 4'(r1), 4'(c1), 4'(r0), 4'(c0)};
  endfunction

  task automatic model_zero();
    for (int unsigned r = 0; r < ROWS; r++) begin
      m_board[r] = '0;
      e_board[r] = '0;
      p_board[r] = '0;
    end
    m_lines = 0; p_lines = 0; e_lines = 0;
    m_go = 1'b0; p_go = 1'b0; e_go = 1'b0;
    pending = 1'b0;
  endtask

  // Place the piece, then keep only the non-full rows packed at the bottom.
  task automatic model_lock(input logic [31:0] cells, output int unsigned nfull);
    logic [COLS-1:0] tmp [ROWS];
    int dst;
    tmp = m_board;
    for (int k = 0; k < 4; k++) begin
      int r, c;
      r = int'(cells[8*k+4 +: 4]);
      c = int'(cells[8*k +: 4]);
      if (r < int'(ROWS) && c < int'(COLS)) tmp[r][c] = 1'b1;
    end
    nfull = 0;
    dst = int'(ROWS);
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (tmp[i] == '1) begin
        nfull++;
      end else begin
        dst--;
        m_board[dst] = tmp[i];
      end
    end
    for (int i = 0; i < dst; i++) m_board[i] = '0;
    m_lines = (nfull > MAX_CLEAR) ? MAX_CLEAR : nfull;
    m_go    = m_go | (m_board[0] != '0);
  endtask

  // Raise a lock request at a falling edge and hold it until accepted.
  task automatic do_lock(input logic [31:0] cells);
    int unsigned waited;
    int unsigned nfull;
    waited = 0;
    @(negedge Clk);
    lock_cells = cells;
    lock_valid = 1'b1;
    while (!lock_ready && waited < 200) begin
      @(negedge Clk);
      waited++;
    end
    if (!lock_ready) begin
      chk("lock_accept_timeout", 32'd0, 32'd1);
      lock_valid = 1'b0;
    end else begin
      @(posedge Clk);
      #1;
      lock_valid = 1'b0;
      acc_cyc = cyc;
      model_lock(cells, nfull);
      p_board  = m_board;
      p_lines  = m_lines;
      p_go     = m_go;
      done_cyc = acc_cyc + 13 + 2 * nfull;
      pending  = 1'b1;
    end
  endtask

  // Count falling edges from acceptance until done is seen.
  task automatic wait_done(output int unsigned lat);
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (!done && lat < 100);
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic lock_wait(input string name, input logic [31:0] cells, input int unsigned exp_lat);
    int unsigned lat;
    do_lock(cells);
    wait_done(lat);
    chk({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic do_clear(input bit with_lock);
    @(negedge Clk);
    clear_all = 1'b1;
    if (with_lock) begin
      lock_cells = cells4(0, 0, 0, 1, 0, 2, 0, 3);
      lock_valid = 1'b1;
    end
    @(posedge Clk);
    #1;
    clear_all  = 1'b0;
    lock_valid = 1'b0;
    model_zero();
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge Clk) begin : compare
    bit in_seq;
    bit at_done;
    in_seq  = pending && (cyc <= done_cyc);
    at_done = pending && (cyc == done_cyc);
    if (at_done) begin
      e_board = p_board;
      e_lines = p_lines;
      e_go    = p_go;
      pending = 1'b0;
    end
    chk("busy", 32'(busy), 32'(in_seq));
    chk("lock_ready", 32'(lock_ready), 32'(!in_seq));
    chk("done", 32'(done), 32'(at_done));
    chk("lines_cleared", 32'(lines_cleared), e_lines);
    chk("game_over", 32'(game_over), 32'(e_go));
    if (!in_seq || at_done) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        chk($sformatf("arr%0d", r), 32'(dut_rows[r]), 32'(e_board[r]));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned prev_done;
    Reset      = 1'b1;
    clear_all  = 1'b0;
    lock_valid = 1'b0;
    lock_cells = '0;
    model_zero();
    #1;
    chk("rst_lock_ready", 32'(lock_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_lines", 32'(lines_cleared), 32'd0);
    chk("rst_game_over", 32'(game_over), 32'd0);
    chk("rst_arr11", 32'(arr11), 32'd0);
    #12 Reset = 1'b0;

    // T1: flat piece on the bottom row, nothing cleared.
    lock_wait("t1", cells4(11, 0, 11, 1, 11, 2, 11, 3), 14);
    chk("t1_arr11", 32'(arr11), 32'h00F);
    chk("t1_lines", 32'(lines_cleared), 32'd0);
    chk("t1_game_over", 32'(game_over), 32'd0);

    // T2: bottom row 0x3F0 completed by cols 0..3 -> one line.
    do_clear(1'b0);
    lock_wait("t2_pre1", cells4(11, 4, 11, 5, 11, 6, 11, 7), 14);
    lock_wait("t2_pre2", cells4(11, 8, 11, 9, 11, 8, 11, 9), 14);
    chk("t2_pre_arr11", 32'(arr11), 32'h3F0);
    lock_wait("t2", cells4(11, 0, 11, 1, 11, 2, 11, 3), 16);
    chk("t2_arr11", 32'(arr11), 32'h000);
    chk("t2_lines", 32'(lines_cleared), 32'd1);

    // T3: four 0x3FE rows completed by a vertical I -> four lines.
    for (int r = 8; r <= 11; r++) begin
      lock_wait("t3_pre", cells4(r, 1, r, 2, r, 3, r, 4), 14);
      lock_wait("t3_pre", cells4(r, 5, r, 6, r, 7, r, 8), 14);
      lock_wait("t3_pre", cells4(r, 9, r, 9, r, 9, r, 9), 14);
    end
    chk("t3_pre_arr8", 32'(arr8), 32'h3FE);
    lock_wait("t3", cells4(8, 0, 9, 0, 10, 0, 11, 0), 22);
    chk("t3_lines", 32'(lines_cleared), 32'd4);
    chk("t3_arr8", 32'(arr8), 32'h000);
    chk("t3_arr11", 32'(arr11), 32'h000);

    // T4: row 10 cleared above a partial row 11; old row 9 drops into row 10.
    lock_wait("t4_pre", cells4(9, 0, 9, 2, 9, 4, 9, 6), 14);
    lock_wait("t4_pre", cells4(9, 8, 9, 8, 9, 8, 9, 8), 14);
    lock_wait("t4_pre", cells4(10, 0, 10, 1, 10, 2, 10, 3), 14);
    lock_wait("t4_pre", cells4(10, 4, 10, 5, 10, 6, 10, 7), 14);
    lock_wait("t4_pre", cells4(10, 8, 10, 8, 10, 8, 10, 8), 14);
    lock_wait("t4", cells4(10, 9, 11, 0, 11, 0, 11, 0), 16);
    chk("t4_arr11", 32'(arr11), 32'h001);
    chk("t4_arr10", 32'(arr10), 32'h155);
    chk("t4_arr9", 32'(arr9), 32'h000);
    chk("t4_lines", 32'(lines_cleared), 32'd1);

    // T6a: off-board cells leave the board unchanged.
    lock_wait("t6_offboard", cells4(12, 0, 3, 10, 12, 0, 3, 10), 14);
    chk("t6_arr3", 32'(arr3), 32'h000);
    chk("t6_arr11", 32'(arr11), 32'h001);
    chk("t6_lines", 32'(lines_cleared), 32'd0);

    // T6b: a request raised while busy is taken on the first IDLE cycle.
    do_lock(cells4(5, 5, 5, 5, 5, 5, 5, 5));
    prev_done = done_cyc;
    do_lock(cells4(5, 6, 5, 6, 5, 6, 5, 6));
    chk("t6_accept_cycle", acc_cyc, prev_done + 2);
    begin
      int unsigned lat;
      wait_done(lat);
      chk("t6_latency", lat, 14);
    end
    chk("t6_arr5", 32'(arr5), 32'h060);

    // T6c: reset during SCAN clears everything asynchronously.
    do_lock(cells4(2, 2, 2, 2, 2, 2, 2, 2));
    repeat (3) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    model_zero();
    chk("t6_arst_busy", 32'(busy), 32'd0);
    chk("t6_arst_lock_ready", 32'(lock_ready), 32'd1);
    chk("t6_arst_done", 32'(done), 32'd0);
    chk("t6_arst_lines", 32'(lines_cleared), 32'd0);
    chk("t6_arst_arr5", 32'(arr5), 32'h000);
    chk("t6_arst_arr10", 32'(arr10), 32'h000);
    chk("t6_arst_arr11", 32'(arr11), 32'h000);
    @(negedge Clk);
    #2 Reset = 1'b0;

    // T5: a cell in the top row sets game_over; locks still processed after.
    lock_wait("t5", cells4(0, 5, 0, 5, 0, 5, 0, 5), 14);
    chk("t5_game_over", 32'(game_over), 32'd1);
    chk("t5_arr0", 32'(arr0), 32'h020);
    lock_wait("t5_after_go", cells4(11, 0, 11, 0, 11, 0, 11, 0), 14);
    chk("t5_arr11", 32'(arr11), 32'h001);
    chk("t5_game_over_sticky", 32'(game_over), 32'd1);
    do_clear(1'b1);
    chk("t5_clr_game_over", 32'(game_over), 32'd0);
    chk("t5_clr_busy", 32'(busy), 32'd0);
    chk("t5_clr_arr0", 32'(arr0), 32'h000);
    chk("t5_clr_arr11", 32'(arr11), 32'h000);
    repeat (3) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
